// File: rtl/audio_frame_demux.sv
// Audio frame demultiplexer: hunts for SYNC_WORD, gathers six 16-bit samples, commits them on Data_Clk.
// Define AUDIO_FRAME_CHECKSUM_EN to append and verify an XOR checksum byte after the 12 payload bytes.
module audio_frame_demux #(
    parameter logic [15:0] SYNC_WORD = 16'hA55A,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [7:0]  Data,
    input  logic        Data_Valid,
    output logic [95:0] Audio,
    output logic        Data_Clk,
    output logic        Locked,
    output logic        Frame_Error,
    output logic [7:0]  Error_Count
);
    localparam int unsigned TW       = $clog2(TIMEOUT + 1);
    localparam logic [3:0]  LAST_IDX = 4'd11;

`ifdef AUDIO_FRAME_CHECKSUM_EN
    typedef enum logic [1:0] {HUNT, SYNC2, PAYLOAD, CHECK} state_t;
`else
    typedef enum logic [1:0] {HUNT, SYNC2, PAYLOAD} state_t;
`endif

    state_t        r_state, w_next_state;
    logic [3:0]    r_index;
    logic [TW-1:0] r_timer;
    logic [95:0]   r_shadow, w_shadow_next;
    logic [6:0]    w_offset;
    logic          w_timeout, w_store, w_commit, w_bad;
    logic [95:0]   r_audio;
    logic          r_data_clk, r_locked, r_frame_error;
    logic [7:0]    r_error_count;
`ifdef AUDIO_FRAME_CHECKSUM_EN
    logic [7:0]    r_xor;
`endif

    // A timeout wins over a coincident byte; that byte is then judged as if in HUNT.
    assign w_timeout = (r_state != HUNT) && (r_timer == TW'(TIMEOUT));
    // Even index is the high byte of channel index/2.
    assign w_offset  = {r_index[3:1], 4'b0000} + (r_index[0] ? 7'd0 : 7'd8);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_next_state = r_state;
        w_store      = 1'b0;
        w_commit     = 1'b0;
        w_bad        = 1'b0;
        if (w_timeout) begin
            w_bad        = 1'b1;
            w_next_state = (Data_Valid && Data == SYNC_WORD[15:8]) ? SYNC2 : HUNT;
        end else if (Data_Valid) begin
            case (r_state)
                HUNT: begin
                    if (Data == SYNC_WORD[15:8]) w_next_state = SYNC2;
                end
                SYNC2: begin
                    if (Data == SYNC_WORD[7:0])       w_next_state = PAYLOAD;
                    else if (Data == SYNC_WORD[15:8]) w_next_state = SYNC2;
                    else                              w_next_state = HUNT;
                end
                PAYLOAD: begin
                    w_store = 1'b1;
                    if (r_index == LAST_IDX) begin
`ifdef AUDIO_FRAME_CHECKSUM_EN
                        w_next_state = CHECK;
`else
                        w_next_state = HUNT;
                        w_commit     = 1'b1;
`endif
                    end
                end
`ifdef AUDIO_FRAME_CHECKSUM_EN
                CHECK: begin
                    w_next_state = HUNT;
                    if (Data == r_xor) w_commit = 1'b1;
                    else               w_bad    = 1'b1;
                end
`endif
                default: w_next_state = HUNT;
            endcase
        end
    end

    always_comb begin
        w_shadow_next = r_shadow;
        if (w_store) w_shadow_next[w_offset +: 8] = Data;
    end

    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (Reset) r_state <= HUNT;
        else       r_state <= w_next_state;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            // NOTE: the shadow register is explicitly cleared so a fresh start never exposes stale samples.
            r_shadow      <= '0;
            r_index       <= '0;
            r_timer       <= '0;
            r_audio       <= '0;
            r_data_clk    <= 1'b0;
            r_locked      <= 1'b0;
            r_frame_error <= 1'b0;
            r_error_count <= '0;
`ifdef AUDIO_FRAME_CHECKSUM_EN
            r_xor         <= '0;
`endif
        end else begin
            r_shadow      <= w_shadow_next;
            r_frame_error <= w_bad;

            if (w_next_state == HUNT || Data_Valid) r_timer <= '0;
            else                                    r_timer <= r_timer + TW'(1);

            if (w_next_state != PAYLOAD) r_index <= '0;
            else if (w_store)            r_index <= r_index + 4'd1;

`ifdef AUDIO_FRAME_CHECKSUM_EN
            if (w_store)                                 r_xor <= r_xor ^ Data;
            else if (r_state == HUNT || r_state == SYNC2) r_xor <= '0;
`endif

            if (w_commit) begin
                r_audio    <= w_shadow_next;
                r_data_clk <= ~r_data_clk;
                r_locked   <= 1'b1;
            end
            if (w_bad) begin
                r_locked <= 1'b0;
                if (r_error_count != 8'hFF) r_error_count <= r_error_count + 8'd1;
            end
        end
    end

    assign Audio       = r_audio;
    assign Data_Clk    = r_data_clk;
    assign Locked      = r_locked;
    assign Frame_Error = r_frame_error;
    assign Error_Count = r_error_count;

endmodule

// File: doc/audio_frame_demux.md
AUDIO_FRAME_DEMUX -- requirements
Module: audio_frame_demux

Interface
REQ-001 The block SHALL have parameter SYNC_WORD, default 16'hA55A: the two-byte frame header, MSB byte first.
REQ-002 The block SHALL have parameter TIMEOUT, default 1024: the maximum number of Clk cycles allowed between accepted bytes inside a frame.
REQ-003 The block SHALL have port Clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port Data, input, 8 bits: the received byte.
REQ-006 The block SHALL have port Data_Valid, input, 1 bit: Data is accepted on any cycle where Data_Valid is high.
REQ-007 The block SHALL have port Audio, output, 96 bits: six 16-bit two's-complement samples; channel k occupies bits [16k+15:16k].
REQ-008 The block SHALL have port Data_Clk, output, 1 bit: a level that toggles once per committed frame.
REQ-009 The block SHALL have port Locked, output, 1 bit: high while the frame stream is valid.
REQ-010 The block SHALL have port Frame_Error, output, 1 bit: a one-cycle pulse on each dropped frame.
REQ-011 The block SHALL have port Error_Count, output, 8 bits: a saturating count of dropped frames.

Function
REQ-012 The FSM SHALL have the states HUNT, SYNC2, PAYLOAD and CHECK, and advances only on accepted bytes, except on timeout.
REQ-013 HUNT: on a byte equal to SYNC_WORD[15:8], the FSM SHALL go to SYNC2; otherwise it stays in HUNT.
REQ-014 SYNC2: on a byte equal to SYNC_WORD[7:0], the FSM SHALL go to PAYLOAD with the byte index at 0.
REQ-015 SYNC2: on a byte equal to SYNC_WORD[15:8], the FSM SHALL stay in SYNC2; on any other byte it SHALL return to HUNT. Neither case is an error.
REQ-016 PAYLOAD: the FSM SHALL store 12 bytes into a shadow register, MSB first per channel, channel 0 first, and keep a running XOR of them.
REQ-017 After byte 11, the FSM SHALL go to CHECK.
REQ-018 CHECK: if the received byte equals the running XOR, the frame SHALL be good; otherwise the frame SHALL be bad.
REQ-019 The FSM SHALL return to HUNT after every CHECK byte, whether the frame was good or bad.
REQ-020 Good frame: on the cycle after the CHECK byte is accepted, the block SHALL copy the shadow register to Audio, toggle Data_Clk and set Locked, all on the same edge.
REQ-021 Audio SHALL change only on commit edges, so Audio is stable whenever Data_Clk toggles.
REQ-022 Bad frame: on the cycle after the CHECK byte, the block SHALL pulse Frame_Error, clear Locked and increment Error_Count. Audio and Data_Clk SHALL be unchanged.
REQ-023 Timeout: if the FSM is in SYNC2, PAYLOAD or CHECK and TIMEOUT consecutive cycles pass without Data_Valid, the block SHALL return to HUNT and take the bad-frame actions.
REQ-024 The timeout counter SHALL clear on every accepted byte and SHALL be held at zero in HUNT.
REQ-025 Error_Count SHALL saturate at 255 and never wrap.
REQ-026 Data_Valid held high for consecutive cycles SHALL give one byte per cycle, with no throttling.
REQ-027 If Data_Valid is high on the same edge that a timeout fires, the timeout SHALL take priority and the byte SHALL be processed in HUNT.

Reset
REQ-028 While Reset is high, the block SHALL hold state HUNT, byte index 0, running XOR 0, timeout counter 0 and shadow register 0.
REQ-029 While Reset is high, the block SHALL hold the outputs Audio=0, Data_Clk=0, Locked=0, Frame_Error=0 and Error_Count=0.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame with no Frame_Error pulse and no Error_Count increment.
REQ-031 Data_Valid SHALL be ignored on every cycle where Reset is high.

Configuration
REQ-032 With macro AUDIO_FRAME_CHECKSUM_EN defined, the frame SHALL be 15 bytes (sync 2, payload 12, checksum 1) and CHECK SHALL operate as specified above.
REQ-033 Without AUDIO_FRAME_CHECKSUM_EN, the CHECK state and the XOR logic SHALL be absent and every frame SHALL be 14 bytes.
REQ-034 Without AUDIO_FRAME_CHECKSUM_EN, commit SHALL occur on the cycle after payload byte 11 is accepted. Only a timeout SHALL produce Frame_Error.

Verification (AUDIO_FRAME_CHECKSUM_EN defined unless noted)
REQ-035 Scenario, good frame: send A5 5A, then 00 01 00 02 00 03 00 04 00 05 00 06, then checksum 07. Required: Audio channels 0 to 5 = 1..6, Data_Clk toggles 0->1 and Locked=1, one cycle after the checksum byte.
REQ-036 Scenario, bad checksum: send the good frame, then the same frame with checksum 08. Required: Frame_Error pulses for 1 cycle, Locked=0, Error_Count=1, and Audio and Data_Clk are unchanged.
REQ-037 Scenario, false sync: send A5 A5 5A followed by a valid payload and checksum. Required: the frame commits normally.
REQ-038 Scenario, timeout: send A5 5A 00 01, then Data_Valid low for 1024 cycles. Required: Frame_Error pulses exactly once and the FSM is in HUNT. A following valid frame commits.
REQ-039 Scenario, saturation and reset: force 300 bad frames. Required: Error_Count=255. Then assert Reset for 1 cycle mid-frame. Required: all outputs are 0 and there is no Frame_Error pulse.
REQ-040 Scenario, macro undefined: send A5 5A followed by 12 payload bytes. Required: commit and Data_Clk toggle one cycle after the 12th payload byte, and the next byte is treated as a HUNT byte.
